// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle between CPU fetch/data ports, the arbiter
// and the single-port memory macro.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;
    logic              d_req;
    logic              d_rw;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              mem_cs;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall;

    modport slave (
        input  i_req, i_addr, d_req, d_rw, d_addr, d_wdata, mem_rdata,
        output i_rdata, i_ready, d_rdata, d_ready,
        output mem_cs, mem_rw, mem_addr, mem_wdata, stall
    );

    modport master (
        output i_req, i_addr, d_req, d_rw, d_addr, d_wdata, mem_rdata,
        input  i_rdata, i_ready, d_rdata, d_ready,
        input  mem_cs, mem_rw, mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory
// between the instruction-fetch and load/store ports.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 1
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    state_t            state_nx;
    logic              take;
    logic              pick_d;
    logic              cap;
    logic              grant_d;
    logic              last_d;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        cnt;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              i_rdy;
    logic              d_rdy;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        pick_d   = 1'b0;
        cap      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    take     = 1'b1;
                    // on a tie, the side that did not win last time goes
                    pick_d   = bus.d_req && (!bus.i_req || !last_d);
                    state_nx = ISSUE;
                end
            end
            ISSUE: state_nx = rw_q ? RESP : WAIT;
            WAIT: begin
                if (cnt == 3'd0) begin
                    cap      = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_d   <= 1'b0;
            last_d    <= 1'b1;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cnt       <= 3'd0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if (take) begin
                grant_d <= pick_d;
                last_d  <= pick_d;
                rw_q    <= pick_d & bus.d_rw;
                addr_q  <= pick_d ? bus.d_addr : bus.i_addr;
                wdata_q <= pick_d ? bus.d_wdata : '0;
            end
            // WAIT lasts LAT cycles; capture happens when cnt reaches 0
            if (state == ISSUE)
                cnt <= 3'(LAT - 1);
            else if (state == WAIT && cnt != 3'd0)
                cnt <= cnt - 3'd1;
            if (cap && grant_d)
                d_rdata_q <= bus.mem_rdata;
            if (cap && !grant_d)
                i_rdata_q <= bus.mem_rdata;
        end
    end

    assign i_rdy = (state == RESP) && !grant_d;
    assign d_rdy = (state == RESP) && grant_d;

    assign bus.mem_cs    = (state == ISSUE);
    assign bus.mem_rw    = rw_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_ready   = i_rdy;
    assign bus.d_ready   = d_rdy;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.stall     = (bus.i_req & ~i_rdy) | (bus.d_req & ~d_rdy);
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous data/instruction memory between the CPU instruction-fetch port and the CPU load/store port.
- Sits between mycpu-level request ports and the memory macro. Sequences each access issue→wait→respond.
- Round-robin arbitration on simultaneous requests.
- Raises a stall so the PC and regfile hold while an access is outstanding.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LAT, 1, memory read latency in cycles from the mem_cs cycle to the mem_rdata-valid cycle; legal range 1..7.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_req  in  1  fetch request; held until i_ready
- i_addr  in  ADDR_W  fetch address; stable while i_req
- i_rdata  out  DATA_W  fetch data; valid when i_ready
- i_ready  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; held until d_ready
- d_rw  in  1  1=write, 0=read; stable while d_req
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data; valid when d_ready
- d_ready  out  1  one-cycle data completion pulse
- mem_cs  out  1  memory select; exactly one cycle per access
- mem_rw  out  1  1=write, 0=read
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid LAT cycles after the mem_cs cycle
- stall  out  1  (i_req & ~i_ready) | (d_req & ~d_ready); combinational

Behaviour:
- Clocking: all state updates on the posedge of clk.
- Reset values: state=IDLE; mem_cs, mem_rw, i_ready, d_ready = 0; mem_addr, mem_wdata, i_rdata, d_rdata = 0; wait counter = 0; last_grant = DATA, so fetch wins the first tie after reset.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request → remain in IDLE.
  - Exactly one request → grant it.
  - Both requests → grant the requester that is not last_grant.
  - On grant: register grant id, rw, addr and wdata (fetch: rw=0, wdata=0); update last_grant; go to ISSUE.
- ISSUE: mem_cs=1 with the registered rw/addr/wdata for this one cycle only.
  - Write → go to RESP.
  - Read with LAT=1 → go to WAIT and latch on the next cycle.
  - Otherwise load counter = LAT-1 and go to WAIT.
- WAIT: decrement the counter each cycle.
  - In the cycle that is LAT cycles after ISSUE, capture mem_rdata into i_rdata or d_rdata (granted side only) and go to RESP.
- RESP: pulse the granted ready for exactly one cycle. The other ready stays 0. Go to IDLE.
- Latency from request seen in IDLE at cycle t:
  - Write: mem_cs at t+1, ready at t+2.
  - Read: mem_cs at t+1, data captured at t+1+LAT, ready at t+2+LAT.
- No re-grant in the RESP cycle. A requester still shows req high during its ready cycle; arbitration resumes only in IDLE.
- Read-data registers hold their value until the next read capture for the same side.
- Requests arriving while busy are not lost. They stay pending because req is held, and are arbitrated in the next IDLE.
- A request deasserted before its ready is a protocol violation; the in-flight access still completes.
- stall is high from the request cycle through the cycle before ready. It is low in the ready cycle.
- Synchronous reset in any state returns to IDLE next edge. An in-flight access is abandoned: no ready pulse, and mem_cs is 0 the cycle after reset.

Test Plan:
1. LAT=1, single fetch i_addr=0x00000040 at t, memory returns 0x24010005 → mem_cs=1, mem_rw=0, mem_addr=0x40 at t+1; i_ready=1 and i_rdata=0x24010005 at t+3; stall=1 at t..t+2.
2. Single store, d_rw=1, d_addr=0x100, d_wdata=0xDEADBEEF → mem_cs=1, mem_rw=1, mem_wdata=0xDEADBEEF at t+1; d_ready at t+2; i_ready stays 0.
3. Both requests at t immediately after reset → fetch granted first; data access issued in the cycle after the fetch RESP+IDLE; grants alternate I,D,I,D over 4 sustained dual requests.
4. LAT=3 load from 0x200 returning 0x12345678 → mem_cs one cycle only at t+1; d_ready at t+5 with d_rdata=0x12345678.
5. Assert rst during WAIT → IDLE next edge; no ready pulse; all outputs return to 0; the following fetch completes normally.
6. Continuous d_req with i_req rising mid-transaction → fetch is granted at the next IDLE (round-robin); no starvation over 10 accesses.
